cam_param: RTL

//  Parametrised content-addressable memory; successor to the fixed 32x32 CAM.
//  - Independent data width and depth, per-entry valid bits, explicit invalidate port.
//  - Masked (ternary-key) search, registered outputs, multi-hit flag.
//  - Sits beside the lookup/tag datapath and is driven directly by the controlling FSM.

---
 rtl/cam_pkg.sv | 18 +
 rtl/cam_prio_enc.sv | 29 ++
 rtl/cam_param.sv | 93 +++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// Shared types and helpers for the parametrised CAM and the logic that drives it.
// Operation codes are used by the controller and the bench to name requests.
package cam_pkg;

   typedef enum logic [2:0] {
      CAM_NONE,
      CAM_READ,
      CAM_WRITE,
      CAM_INVAL,
      CAM_SEARCH
   } cam_op_e;

   // Index width for n entries, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// Match-vector priority encoder: lowest set index, any-set flag and two-or-more flag.
// Purely combinational; the CAM registers its outputs.
module cam_prio_enc #(
   parameter int N          = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic [N-1:0]          match,
   output logic [ADDR_WIDTH-1:0] index,
   output logic                  any,
   output logic                  multi
);

   always_comb begin
      index = '0;
      any   = 1'b0;
      multi = 1'b0;
      // Walk downwards so the last assignment is the lowest matching index.
      for (int i = N - 1; i >= 0; i--) begin
         if (match[i]) index = ADDR_WIDTH'(i);
      end
      for (int i = 0; i < N; i++) begin
         if (match[i]) begin
            if (any) multi = 1'b1;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cam_param.sv
// Parametrised CAM with per-entry valid bits, masked search and registered results.
// Reads and searches observe the contents as they were before this cycle's updates.
module cam_param
   import cam_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = clog2_min1(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  read_enable_i,
   input  logic [ADDR_WIDTH-1:0] read_index_i,
   input  logic                  write_enable_i,
   input  logic [ADDR_WIDTH-1:0] write_index_i,
   input  logic [DATA_WIDTH-1:0] write_data_i,
   input  logic                  invalidate_enable_i,
   input  logic [ADDR_WIDTH-1:0] invalidate_index_i,
   input  logic                  search_enable_i,
   input  logic [DATA_WIDTH-1:0] search_data_i,
   input  logic [DATA_WIDTH-1:0] search_mask_i,
   output logic                  read_valid_o,
   output logic [DATA_WIDTH-1:0] read_value_o,
   output logic                  search_valid_o,
   output logic                  search_hit_o,
   output logic [ADDR_WIDTH-1:0] search_index_o,
   output logic                  search_multi_o
);

   localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] entry [DEPTH];
   logic [DEPTH-1:0]      valid;
   logic [DEPTH-1:0]      match;

   logic [ADDR_WIDTH-1:0] enc_index;
   logic                  enc_any;
   logic                  enc_multi;
   logic                  read_ok;

   // Out-of-range write/invalidate indices never equal any g, so they fall through harmlessly.
   for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      logic [DATA_WIDTH-1:0] data;
      logic                  vld;

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            data <= '0;
            vld  <= 1'b0;
         end else if (write_enable_i && write_index_i == ADDR_WIDTH'(g)) begin
            data <= write_data_i;
            vld  <= 1'b1;
         end else if (invalidate_enable_i && invalidate_index_i == ADDR_WIDTH'(g)) begin
            vld  <= 1'b0;
         end
      end

      assign entry[g] = data;
      assign valid[g] = vld;
      assign match[g] = vld & (((data ^ search_data_i) & search_mask_i) == '0);
   end

   cam_prio_enc #(
      .N          (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_prio_enc (
      .match (match),
      .index (enc_index),
      .any   (enc_any),
      .multi (enc_multi)
   );

   assign read_ok = read_enable_i && ({1'b0, read_index_i} < LIMIT) && valid[read_index_i];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         read_valid_o   <= 1'b0;
         read_value_o   <= '0;
         search_valid_o <= 1'b0;
         search_hit_o   <= 1'b0;
         search_index_o <= '0;
         search_multi_o <= 1'b0;
      end else begin
         read_valid_o   <= read_ok;
         read_value_o   <= read_ok ? entry[read_index_i] : '0;
         search_valid_o <= search_enable_i;
         search_hit_o   <= search_enable_i & enc_any;
         search_index_o <= search_enable_i ? enc_index : '0;
         search_multi_o <= search_enable_i & enc_multi;
      end
   end

endmodule
